ex_stage: RTL and testbench
===========================

Name: ex_stage

Overview:
- Execute stage of the 32-bit pipeline; sits directly downstream of the RR→EX pipeline register and consumes its *_EX outputs.
- Single-cycle ALU for simple ops; iterative 32-cycle unit for MUL/DIVU/REMU.
- Owns the EX→MEM pipeline register.
- Drives ex_stall back to the RR→EX register enable (enable = ~ex_stall).

Parameters:
DATA_W, 32, datapath width; only 32 is supported.
MD_ITER, 32, iterations of multiply/divide; must equal DATA_W.

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
mem_stall  in  1  downstream hold; EX→MEM register keeps its value while high
pc_EX  in  32  instruction PC
R1_data_EX  in  32  source operand 1
R2_data_EX  in  32  source operand 2 / store data
R3_addr_EX  in  5  destination register
func_EX  in  6  ALU function
opr_alu1_EX  in  1  operand A select: 0=R1, 1=pc
opr_alu2_EX  in  2  operand B select: 0=R2, 1=imm, 2=32'd4, 3=0
mem_rw_EX  in  1  memory write request
R3_dcntrl_EX  in  2  writeback control (0 = no writeback)
imm_sgn_extd_EX  in  32  sign-extended immediate
opcode_EX  in  6  opcode, passed through
ex_stall  out  1  combinational; high = upstream must hold
alu_result_MEM  out  32  registered result
store_data_MEM  out  32  registered R2_data
R3_addr_MEM  out  5  registered
mem_rw_MEM  out  1  registered
R3_dcntrl_MEM  out  2  registered
opcode_MEM  out  6  registered

Behaviour:
Reset:
- Synchronous reset; clock is clk.
- On reset, all *_MEM outputs = 0 and the FSM goes to IDLE.
- Reset takes priority over everything, including a multi-cycle op in flight; that op is abandoned.

ALU result (combinational), with A and B selected as above:
- ADD 6'h20: A+B, wrap mod 2^32.
- SUB 6'h22: A-B, wrap mod 2^32.
- AND 6'h24: A&B.
- OR 6'h25: A|B.
- XOR 6'h26: A^B.
- SLT 6'h2A: signed A<B gives 1, else 0.
- SLL 6'h00: A<<B[4:0].
- SRL 6'h02: logical A>>B[4:0].
- SRA 6'h03: arithmetic A>>>B[4:0].
- Any other non-muldiv func: result 0.

Multi-cycle ops (is_md):
- MUL 6'h18: low 32 bits of A*B.
- DIVU 6'h1A: unsigned quotient.
- REMU 6'h1B: unsigned remainder.
- Implemented as a shift-add / restoring-divide iterator: one bit per cycle, 6-bit iteration counter.
- Divide by zero: quotient = 32'hFFFFFFFF, remainder = A.

FSM states IDLE, BUSY, DONE:
- IDLE:
  - If is_md and !mem_stall: latch A, B and the op, clear accumulators, counter=0, go to BUSY.
  - Otherwise, single-cycle path.
- BUSY:
  - One iteration per cycle; counter++.
  - When counter == MD_ITER-1, go to DONE.
- DONE:
  - If !mem_stall: load the md result into the EX→MEM register, go to IDLE.
  - If mem_stall: stay in DONE.
  - DONE never restarts the op, even though the inputs still show the same instruction.

ex_stall:
- ex_stall = mem_stall | (state==IDLE & is_md) | (state==BUSY).
- ex_stall is low in DONE unless mem_stall is high.
- Timing: a muldiv presented in cycle 0 keeps ex_stall high for cycles 0..32. The result appears on *_MEM after the cycle-33 edge, giving 34-cycle latency.

EX→MEM register update, priority order:
1. reset → clear.
2. mem_stall → hold.
3. state==IDLE & is_md, or BUSY → insert bubble: mem_rw_MEM=0, R3_dcntrl_MEM=0, alu_result/store_data/R3_addr/opcode = 0.
4. Otherwise capture:
   - alu_result_MEM = ALU or md result.
   - store_data_MEM = R2_data_EX.
   - R3_addr_MEM, mem_rw_MEM, R3_dcntrl_MEM, opcode_MEM copied from the inputs.
   - Single-cycle ops have 1-cycle latency.

Input stability:
- Inputs are guaranteed stable while ex_stall is high, because upstream is held.
- The block still uses its latched operands in BUSY/DONE.

Back-to-back operation:
- A muldiv directly following a muldiv: IDLE is re-entered after DONE and the new op is detected in that IDLE cycle.
- No idle gap is required between a single-cycle op and a muldiv.

Test Plan:
1. Reset during BUSY (cycle 10 of a MUL) → next cycle all *_MEM = 0, ex_stall = 0 if inputs are not muldiv, FSM in IDLE.
2. ADD with R1=32'hFFFFFFFF, imm=1, opr_alu2=1, R3_addr=5, R3_dcntrl=1 → next edge: alu_result_MEM=0, R3_addr_MEM=5, R3_dcntrl_MEM=1, ex_stall never high.
3. SRA with R1=32'h80000000, R2=4 → 32'hF8000000. SLT with R1=-1, R2=1 → 1. Unknown func 6'h3F → 0.
4. MUL with R1=32'h0001_0003, R2=32'h0002_0005 → ex_stall high exactly 33 cycles; bubbles (mem_rw_MEM=0, R3_dcntrl_MEM=0) during the stall; then alu_result_MEM=32'h000B_000F with the instruction's R3_addr.
5. DIVU 100/7 → 14; REMU 100/7 → 2; DIVU 5/0 → 32'hFFFFFFFF; REMU 5/0 → 5; each with 34-cycle latency.
6. mem_stall asserted in the DONE cycle of a DIVU for 3 cycles → FSM stays in DONE, *_MEM held, ex_stall high; the result loads on the first edge after mem_stall drops. The op is not re-executed.

Source files
------------

// File: rtl/ex_stage.sv
// Execute stage: single-cycle ALU, 32-iteration MUL/DIVU/REMU unit and the EX->MEM register.
module ex_stage #(
   parameter int unsigned DATA_W  = 32,
   parameter int unsigned MD_ITER = 32
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              mem_stall,
   input  logic [DATA_W-1:0] pc_EX,
   input  logic [DATA_W-1:0] R1_data_EX,
   input  logic [DATA_W-1:0] R2_data_EX,
   input  logic [4:0]        R3_addr_EX,
   input  logic [5:0]        func_EX,
   input  logic              opr_alu1_EX,
   input  logic [1:0]        opr_alu2_EX,
   input  logic              mem_rw_EX,
   input  logic [1:0]        R3_dcntrl_EX,
   input  logic [DATA_W-1:0] imm_sgn_extd_EX,
   input  logic [5:0]        opcode_EX,
   output logic              ex_stall,
   output logic [DATA_W-1:0] alu_result_MEM,
   output logic [DATA_W-1:0] store_data_MEM,
   output logic [4:0]        R3_addr_MEM,
   output logic              mem_rw_MEM,
   output logic [1:0]        R3_dcntrl_MEM,
   output logic [5:0]        opcode_MEM
);

   localparam logic [5:0] FnSll  = 6'h00;
   localparam logic [5:0] FnSrl  = 6'h02;
   localparam logic [5:0] FnSra  = 6'h03;
   localparam logic [5:0] FnMul  = 6'h18;
   localparam logic [5:0] FnDivu = 6'h1A;
   localparam logic [5:0] FnRemu = 6'h1B;
   localparam logic [5:0] FnAdd  = 6'h20;
   localparam logic [5:0] FnSub  = 6'h22;
   localparam logic [5:0] FnAnd  = 6'h24;
   localparam logic [5:0] FnOr   = 6'h25;
   localparam logic [5:0] FnXor  = 6'h26;
   localparam logic [5:0] FnSlt  = 6'h2A;

   typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

   state_e state_q, state_d;

   logic [DATA_W-1:0] op_a, op_b, alu_res, md_res;
   logic              is_md, md_start, bubble;

   // Multiply/divide working registers
   logic [DATA_W-1:0] a_q, a_d, b_q, b_d, acc_q, acc_d, quo_q, quo_d;
   logic [5:0]        func_q, func_d;
   logic [5:0]        cnt_q, cnt_d;
   logic [DATA_W:0]   rem_sh;
   logic              rem_ge;

   // Operand selection
   always_comb begin
      op_a = opr_alu1_EX ? pc_EX : R1_data_EX;
      case (opr_alu2_EX)
         2'd0:    op_b = R2_data_EX;
         2'd1:    op_b = imm_sgn_extd_EX;
         2'd2:    op_b = DATA_W'(4);
         default: op_b = '0;
      endcase
   end

   // Single-cycle ALU
   always_comb begin
      alu_res = '0;
      case (func_EX)
         FnAdd:   alu_res = op_a + op_b;
         FnSub:   alu_res = op_a - op_b;
         FnAnd:   alu_res = op_a & op_b;
         FnOr:    alu_res = op_a | op_b;
         FnXor:   alu_res = op_a ^ op_b;
         FnSlt:   alu_res = {{(DATA_W-1){1'b0}}, $signed(op_a) < $signed(op_b)};
         FnSll:   alu_res = op_a << op_b[4:0];
         FnSrl:   alu_res = op_a >> op_b[4:0];
         FnSra:   alu_res = $signed(op_a) >>> op_b[4:0];
         default: alu_res = '0;
      endcase
   end

   assign is_md    = (func_EX == FnMul) || (func_EX == FnDivu) || (func_EX == FnRemu);
   assign md_start = (state_q == StIdle) && is_md && !mem_stall;
   assign bubble   = ((state_q == StIdle) && is_md) || (state_q == StBusy);
   assign ex_stall = mem_stall || ((state_q == StIdle) && is_md) || (state_q == StBusy);

   // FSM next state
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIdle: if (md_start) state_d = StBusy;
         StBusy: if (cnt_q == 6'(MD_ITER - 1)) state_d = StDone;
         StDone: if (!mem_stall) state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   // Restoring divide step: shift next dividend bit into the partial remainder
   assign rem_sh = {acc_q, a_q[DATA_W-1]};
   assign rem_ge = rem_sh >= {1'b0, b_q};

   // Iterator next state: shift-add multiply or restoring divide, one bit per cycle
   always_comb begin
      a_d    = a_q;
      b_d    = b_q;
      acc_d  = acc_q;
      quo_d  = quo_q;
      func_d = func_q;
      cnt_d  = cnt_q;
      if (md_start) begin
         a_d    = op_a;
         b_d    = op_b;
         acc_d  = '0;
         quo_d  = '0;
         func_d = func_EX;
         cnt_d  = '0;
      end else if (state_q == StBusy) begin
         cnt_d = cnt_q + 6'd1;
         a_d   = a_q << 1;
         if (func_q == FnMul) begin
            acc_d = acc_q + (b_q[0] ? a_q : '0);
            b_d   = b_q >> 1;
         end else begin
            acc_d = rem_ge ? DATA_W'(rem_sh - {1'b0, b_q}) : rem_sh[DATA_W-1:0];
            quo_d = {quo_q[DATA_W-2:0], rem_ge};
         end
      end
   end

   assign md_res = (func_q == FnDivu) ? quo_q : acc_q;

   // FSM state and iterator registers
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= StIdle;
         a_q     <= '0;
         b_q     <= '0;
         acc_q   <= '0;
         quo_q   <= '0;
         func_q  <= '0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         a_q     <= a_d;
         b_q     <= b_d;
         acc_q   <= acc_d;
         quo_q   <= quo_d;
         func_q  <= func_d;
         cnt_q   <= cnt_d;
      end
   end

   // EX->MEM register: reset, hold, bubble, then capture
   always_ff @(posedge clk) begin
      if (reset || (!mem_stall && bubble)) begin
         alu_result_MEM <= '0;
         store_data_MEM <= '0;
         R3_addr_MEM    <= '0;
         mem_rw_MEM     <= 1'b0;
         R3_dcntrl_MEM  <= '0;
         opcode_MEM     <= '0;
      end else if (!mem_stall) begin
         alu_result_MEM <= (state_q == StDone) ? md_res : alu_res;
         store_data_MEM <= R2_data_EX;
         R3_addr_MEM    <= R3_addr_EX;
         mem_rw_MEM     <= mem_rw_EX;
         R3_dcntrl_MEM  <= R3_dcntrl_EX;
         opcode_MEM     <= opcode_EX;
      end
   end

endmodule

// File: tb/tb_ex_stage.sv
// Self-checking bench for ex_stage: directed cases plus random ops against an arithmetic model.
module tb_ex_stage;

   logic        clk = 1'b0;
   logic        reset, mem_stall;
   logic [31:0] pc_EX, R1_data_EX, R2_data_EX, imm_sgn_extd_EX;
   logic [4:0]  R3_addr_EX;
   logic [5:0]  func_EX, opcode_EX;
   logic        opr_alu1_EX, mem_rw_EX;
   logic [1:0]  opr_alu2_EX, R3_dcntrl_EX;
   logic        ex_stall;
   logic [31:0] alu_result_MEM, store_data_MEM;
   logic [4:0]  R3_addr_MEM;
   logic        mem_rw_MEM;
   logic [1:0]  R3_dcntrl_MEM;
   logic [5:0]  opcode_MEM;

   int n_assert = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   ex_stage #(.DATA_W(32), .MD_ITER(32)) dut (
      .clk             (clk),
      .reset           (reset),
      .mem_stall       (mem_stall),
      .pc_EX           (pc_EX),
      .R1_data_EX      (R1_data_EX),
      .R2_data_EX      (R2_data_EX),
      .R3_addr_EX      (R3_addr_EX),
      .func_EX         (func_EX),
      .opr_alu1_EX     (opr_alu1_EX),
      .opr_alu2_EX     (opr_alu2_EX),
      .mem_rw_EX       (mem_rw_EX),
      .R3_dcntrl_EX    (R3_dcntrl_EX),
      .imm_sgn_extd_EX (imm_sgn_extd_EX),
      .opcode_EX       (opcode_EX),
      .ex_stall        (ex_stall),
      .alu_result_MEM  (alu_result_MEM),
      .store_data_MEM  (store_data_MEM),
      .R3_addr_MEM     (R3_addr_MEM),
      .mem_rw_MEM      (mem_rw_MEM),
      .R3_dcntrl_MEM   (R3_dcntrl_MEM),
      .opcode_MEM      (opcode_MEM)
   );

   // Reference result straight from the instruction definitions
   function automatic logic [31:0] ref_result(input logic [5:0] f, input logic [31:0] a,
                                              input logic [31:0] b);
      case (f)
         6'h20:   return a + b;
         6'h22:   return a - b;
         6'h24:   return a & b;
         6'h25:   return a | b;
         6'h26:   return a ^ b;
         6'h2A:   return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
         6'h00:   return a << b[4:0];
         6'h02:   return a >> b[4:0];
         6'h03:   return $unsigned($signed(a) >>> b[4:0]);
         6'h18:   return a * b;
         6'h1A:   return (b == 32'd0) ? 32'hFFFF_FFFF : a / b;
         6'h1B:   return (b == 32'd0) ? a : a % b;
         default: return 32'd0;
      endcase
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic drive(input logic [5:0] f, input logic [31:0] r1, input logic [31:0] r2,
                        input logic [31:0] imm, input logic [31:0] pc, input logic sel1,
                        input logic [1:0] sel2, input logic [4:0] r3, input logic [1:0] dc,
                        input logic rw, input logic [5:0] opc);
      func_EX = f; R1_data_EX = r1; R2_data_EX = r2; imm_sgn_extd_EX = imm; pc_EX = pc;
      opr_alu1_EX = sel1; opr_alu2_EX = sel2; R3_addr_EX = r3; R3_dcntrl_EX = dc;
      mem_rw_EX = rw; opcode_EX = opc;
   endtask

   // Present one instruction, follow the stall, check the EX->MEM contents it produces
   task automatic run_op(input string tag, input logic [5:0] f, input logic [31:0] r1,
                         input logic [31:0] r2, input logic [31:0] imm, input logic [31:0] pc,
                         input logic sel1, input logic [1:0] sel2, input logic [4:0] r3,
                         input logic [1:0] dc, input logic rw, input logic [5:0] opc);
      logic [31:0] a, b, exp;
      int          n;
      bit          md;
      drive(f, r1, r2, imm, pc, sel1, sel2, r3, dc, rw, opc);
      a = sel1 ? pc : r1;
      case (sel2)
         2'd0:    b = r2;
         2'd1:    b = imm;
         2'd2:    b = 32'd4;
         default: b = 32'd0;
      endcase
      exp = ref_result(f, a, b);
      md  = (f == 6'h18) || (f == 6'h1A) || (f == 6'h1B);
      #1;
      n = 0;
      while (ex_stall && n < 60) begin
         n++;
         @(negedge clk); #1;
         chk({tag, " bubble rw"}, 32'(mem_rw_MEM), 32'd0);
         chk({tag, " bubble dcntrl"}, 32'(R3_dcntrl_MEM), 32'd0);
      end
      chk({tag, " stall cycles"}, n, md ? 32'd33 : 32'd0);
      @(negedge clk); #1;
      chk({tag, " result"}, alu_result_MEM, exp);
      chk({tag, " store data"}, store_data_MEM, r2);
      chk({tag, " r3 addr"}, 32'(R3_addr_MEM), 32'(r3));
      chk({tag, " dcntrl"}, 32'(R3_dcntrl_MEM), 32'(dc));
      chk({tag, " mem rw"}, 32'(mem_rw_MEM), 32'(rw));
      chk({tag, " opcode"}, 32'(opcode_MEM), 32'(opc));
   endtask

   logic [5:0] fn_list [14] = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h26, 6'h2A, 6'h00, 6'h02,
                                6'h03, 6'h18, 6'h1A, 6'h1B, 6'h3F, 6'h01};

   initial begin
      int n;
      logic [31:0] r2;
      // Reset with a live ADD on the inputs: nothing may be captured
      reset = 1'b1; mem_stall = 1'b0;
      drive(6'h20, 32'h1234_5678, 32'h0000_0011, 32'h5, 32'h100, 1'b0, 2'd0, 5'd7, 2'd1,
            1'b1, 6'h2B);
      repeat (2) @(negedge clk);
      #1;
      chk("reset result", alu_result_MEM, 32'd0);
      chk("reset store", store_data_MEM, 32'd0);
      chk("reset r3", 32'(R3_addr_MEM), 32'd0);
      chk("reset rw", 32'(mem_rw_MEM), 32'd0);
      chk("reset dcntrl", 32'(R3_dcntrl_MEM), 32'd0);
      chk("reset opcode", 32'(opcode_MEM), 32'd0);
      chk("reset stall", 32'(ex_stall), 32'd0);
      reset = 1'b0;

      // Reset during BUSY abandons the multiply
      drive(6'h18, 32'h0001_0003, 32'h0002_0005, 32'd0, 32'd0, 1'b0, 2'd0, 5'd3, 2'd1, 1'b0,
            6'h00);
      repeat (10) @(negedge clk);
      reset = 1'b1;
      drive(6'h20, 32'd1, 32'd2, 32'd0, 32'd0, 1'b0, 2'd0, 5'd4, 2'd1, 1'b0, 6'h00);
      @(negedge clk); #1;
      chk("busy reset result", alu_result_MEM, 32'd0);
      chk("busy reset r3", 32'(R3_addr_MEM), 32'd0);
      chk("busy reset stall", 32'(ex_stall), 32'd0);
      reset = 1'b0;

      run_op("add wrap", 6'h20, 32'hFFFF_FFFF, 32'h0, 32'd1, 32'h40, 1'b0, 2'd1, 5'd5, 2'd1,
             1'b0, 6'h08);
      run_op("sra", 6'h03, 32'h8000_0000, 32'd4, 32'd0, 32'd0, 1'b0, 2'd0, 5'd6, 2'd1, 1'b0,
             6'h00);
      run_op("slt", 6'h2A, 32'hFFFF_FFFF, 32'd1, 32'd0, 32'd0, 1'b0, 2'd0, 5'd7, 2'd1, 1'b0,
             6'h00);
      run_op("unknown", 6'h3F, 32'h1234_5678, 32'h9, 32'd0, 32'd0, 1'b0, 2'd0, 5'd8, 2'd1,
             1'b0, 6'h00);
      run_op("pc plus 4", 6'h20, 32'h0, 32'h5A5A_0000, 32'd0, 32'h0000_1000, 1'b1, 2'd2, 5'd31,
             2'd2, 1'b0, 6'h03);
      run_op("mul", 6'h18, 32'h0001_0003, 32'h0002_0005, 32'd0, 32'd0, 1'b0, 2'd0, 5'd10, 2'd1,
             1'b0, 6'h00);
      run_op("divu", 6'h1A, 32'd100, 32'd7, 32'd0, 32'd0, 1'b0, 2'd0, 5'd11, 2'd1, 1'b0, 6'h00);
      run_op("remu", 6'h1B, 32'd100, 32'd7, 32'd0, 32'd0, 1'b0, 2'd0, 5'd12, 2'd1, 1'b0, 6'h00);
      run_op("divu by 0", 6'h1A, 32'd5, 32'd0, 32'd0, 32'd0, 1'b0, 2'd0, 5'd13, 2'd1, 1'b0,
             6'h00);
      run_op("remu by 0", 6'h1B, 32'd5, 32'd0, 32'd0, 32'd0, 1'b0, 2'd0, 5'd14, 2'd1, 1'b0,
             6'h00);

      // mem_stall held for three cycles in the DONE cycle of a DIVU
      drive(6'h1A, 32'd100, 32'd7, 32'd0, 32'd0, 1'b0, 2'd0, 5'd9, 2'd1, 1'b0, 6'h00);
      #1;
      n = 0;
      while (ex_stall && n < 60) begin
         n++;
         @(negedge clk); #1;
      end
      chk("done stall cycles", n, 32'd33);
      mem_stall = 1'b1;
      #1;
      chk("done hold stall", 32'(ex_stall), 32'd1);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk); #1;
         chk("done hold result", alu_result_MEM, 32'd0);
         chk("done hold r3", 32'(R3_addr_MEM), 32'd0);
         chk("done hold stall", 32'(ex_stall), 32'd1);
      end
      mem_stall = 1'b0;
      #1;
      chk("done release stall", 32'(ex_stall), 32'd0);
      @(negedge clk); #1;
      chk("done release result", alu_result_MEM, 32'd14);
      chk("done release r3", 32'(R3_addr_MEM), 32'd9);
      run_op("after done", 6'h22, 32'd10, 32'd3, 32'd0, 32'd0, 1'b0, 2'd0, 5'd1, 2'd1, 1'b1,
             6'h23);

      // Random mix, including back-to-back multi-cycle ops
      for (int i = 0; i < 40; i++) begin
         r2 = ($urandom_range(0, 2) == 0) ? 32'($urandom_range(0, 20)) : $urandom();
         run_op("random", fn_list[$urandom_range(0, 13)], $urandom(), r2, $urandom(),
                $urandom(), 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
                5'($urandom_range(0, 31)), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                6'($urandom_range(0, 63)));
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
